apu_mem_arbiter: RTL and testbench
==================================

APU_MEM_ARBITER -- requirements
Module: apu_mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4 (range 1..15): max consecutive APU grants while PPU is waiting.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255 (range 1..255): response watchdog limit (REQ-024).
REQ-003 SHALL have ports, clock and reset first:
- clock  in  1  sole clock, all logic on posedge
- reset  in  1  synchronous, active-high
- apu_mem_addr  in  29  APU read address
- apu_mem_read_en  in  1  APU request level
- apu_mem_data  out  64  APU read data
- apu_mem_ready  out  1  APU one-cycle completion pulse
- ppu_mem_addr  in  29  PPU read address
- ppu_mem_read_en  in  1  PPU request level
- ppu_mem_data  out  64  PPU read data
- ppu_mem_ready  out  1  PPU one-cycle completion pulse
- avm_address  out  29  DDR3 read address
- avm_read  out  1  DDR3 read strobe
- avm_waitrequest  in  1  DDR3 stall
- avm_readdata  in  64  DDR3 return data
- avm_readdatavalid  in  1  DDR3 return valid
- mem_err  out  1  one-cycle timeout pulse, coincident with the ready pulse
- busy  out  1  high in any state except IDLE

Function
REQ-004 SHALL hold one outstanding DDR3 read at a time.
REQ-005 SHALL have FSM states IDLE, ISSUE, WAIT_DATA, RESP.
REQ-006 IDLE: if any read_en is high, SHALL latch the winner (owner) and its address and go to ISSUE next cycle; otherwise stay.
REQ-007 Arbitration: APU wins unless the PPU is requesting and starve_cnt == STARVE_LIMIT, or only the PPU is requesting.
REQ-008 starve_cnt (4-bit) SHALL update only on a grant:
- APU granted while PPU requesting: +1, saturating at STARVE_LIMIT
- PPU granted, or APU granted with PPU idle: cleared to 0
REQ-009 ISSUE: avm_read=1 and avm_address=latched address; SHALL hold both stable while avm_waitrequest=1; go to WAIT_DATA on the cycle avm_waitrequest=0.
REQ-010 WAIT_DATA: avm_read=0; on avm_readdatavalid=1, SHALL register avm_readdata into the owner's data register and go to RESP.
REQ-011 RESP: SHALL assert exactly the owner's mem_ready for one cycle, then go to IDLE.
REQ-012 Minimum latency SHALL be: grant in IDLE at cycle N; avm_read at N+1; readdatavalid at N+2; ready at N+3. Next avm_read no earlier than N+5.
REQ-013 Each mem_data output SHALL hold its last delivered value until that port's next completion.
REQ-014 The non-owner port's data and ready SHALL NOT change during a transaction.
REQ-015 Request dropped before grant SHALL generate no DDR3 access.
REQ-016 Request dropped after grant: the transaction SHALL complete and still pulse ready.
REQ-017 read_en still high in the cycle after ready SHALL be treated as a new request.
REQ-018 avm_readdatavalid outside WAIT_DATA SHALL be ignored.
REQ-019 Addresses SHALL pass through unmodified, with no width change.

Reset
REQ-020 While reset=1, SHALL force state=IDLE and clear starve_cnt, owner, and both data registers.
REQ-021 Output values during reset and the cycle after: avm_read=0, avm_address=0, both ready=0, both data=0, mem_err=0, busy=0.
REQ-022 Reset mid-transaction SHALL abandon the read with no ready pulse; a late readdatavalid SHALL be ignored per REQ-018.

Configuration
REQ-023 Macro APU_ARB_TIMEOUT_EN SHALL compile the response watchdog in or out.
REQ-024 With APU_ARB_TIMEOUT_EN defined:
- an 8-bit counter clears on entry to WAIT_DATA and increments each WAIT_DATA cycle without readdatavalid
- on reaching TIMEOUT_CYCLES: go to RESP, deliver 64'h0 to the owner, pulse mem_err with ready
- readdatavalid in the same cycle as the limit SHALL take priority, with no error
REQ-025 Without the macro: no counter; WAIT_DATA waits indefinitely; mem_err tied to 0.

Verification
REQ-026 Bench SHALL cover:
- APU-only read, addr 29'h0000040, waitrequest=0, readdata 64'hDEADBEEF01234567 -> avm_read 1 cycle, apu_mem_ready at N+3 with that data, ppu outputs unchanged.
- Both read_en held continuously, STARVE_LIMIT=4 -> grant sequence APU,APU,APU,APU,PPU,APU,...
- waitrequest high 3 cycles -> avm_read and avm_address stable 4 cycles, single read issued.
- Reset asserted in WAIT_DATA, readdatavalid arrives 2 cycles later -> no ready pulse, busy=0, data registers 0.
- Macro on, TIMEOUT_CYCLES=8, no readdatavalid -> owner ready with data 0 and mem_err=1 together, then IDLE.
- PPU read_en pulsed 1 cycle while APU owns a transaction -> no PPU grant, starve_cnt 0.

Source files
------------

// File: rtl/apu_mem_arbiter.sv
// apu_mem_arbiter
// Shares one DDR3 Avalon-MM read master between the APU and the PPU.
// Only one read is outstanding at a time. The APU has priority, but after
// STARVE_LIMIT consecutive APU grants with the PPU waiting, the PPU wins once.
//
// Ports
//   clock, reset        : sole clock; synchronous active-high reset
//   apu_mem_*           : APU read port (addr/read_en in, data/ready out)
//   ppu_mem_*           : PPU read port (addr/read_en in, data/ready out)
//   avm_*               : DDR3 Avalon-MM read master
//   mem_err             : one-cycle pulse with ready when the watchdog fired
//   busy                : high in any state except IDLE
//
// Build option
//   APU_ARB_TIMEOUT_EN  : when defined, a WAIT_DATA watchdog forces the
//                         transaction to complete with zero data and mem_err
//                         after TIMEOUT_CYCLES cycles with no return data.
//                         When undefined, WAIT_DATA waits indefinitely.
module apu_mem_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [28:0] apu_mem_addr,
  input  logic        apu_mem_read_en,
  output logic [63:0] apu_mem_data,
  output logic        apu_mem_ready,
  input  logic [28:0] ppu_mem_addr,
  input  logic        ppu_mem_read_en,
  output logic [63:0] ppu_mem_data,
  output logic        ppu_mem_ready,
  output logic [28:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [63:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        mem_err,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]  state;
  logic        owner;        // 0 = APU, 1 = PPU
  logic [28:0] addr_q;
  logic [63:0] apu_data_q;
  logic [63:0] ppu_data_q;
  logic [3:0]  starve_cnt;
  logic        grant_ppu;
  logic        any_req;
  logic        timeout_hit;

  assign any_req   = apu_mem_read_en | ppu_mem_read_en;
  assign grant_ppu = ppu_mem_read_en & (~apu_mem_read_en | (starve_cnt == LIMIT));

`ifdef APU_ARB_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wd_cnt;
  logic       err_q;

  // wd_cnt holds the number of WAIT_DATA cycles already spent without data;
  // the watchdog fires in the cycle that would bring it to TIMEOUT_CYCLES.
  // Return data in that same cycle wins because timeout_hit masks on it.
  assign timeout_hit = (state == S_WAIT) & ~avm_readdatavalid & (wd_cnt == WD_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == S_ISSUE)
        wd_cnt <= '0;
      else if (state == S_WAIT && !avm_readdatavalid)
        wd_cnt <= wd_cnt + 8'd1;
      // timeout_hit is only true on the WAIT_DATA -> RESP edge, so err_q is
      // high for exactly the RESP cycle that follows a timeout.
      err_q <= timeout_hit;
    end
  end

  assign mem_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
  // Range guard keeps the watchdog limit referenced in this build.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_bad
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      addr_q     <= '0;
      apu_data_q <= '0;
      ppu_data_q <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner  <= grant_ppu;
            addr_q <= grant_ppu ? ppu_mem_addr : apu_mem_addr;
            state  <= S_ISSUE;
            // Count only APU wins that made a waiting PPU wait longer.
            if (grant_ppu || !ppu_mem_read_en)
              starve_cnt <= '0;
            else if (starve_cnt != LIMIT)
              starve_cnt <= starve_cnt + 4'd1;
          end
        end
        S_ISSUE: begin
          if (!avm_waitrequest)
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (avm_readdatavalid || timeout_hit) begin
            // A timeout delivers zero data to the owner.
            if (owner)
              ppu_data_q <= avm_readdatavalid ? avm_readdata : 64'h0;
            else
              apu_data_q <= avm_readdatavalid ? avm_readdata : 64'h0;
            state <= S_RESP;
          end
        end
        default: state <= S_IDLE;  // S_RESP
      endcase
    end
  end

  assign avm_read      = (state == S_ISSUE);
  assign avm_address   = addr_q;
  assign apu_mem_ready = (state == S_RESP) & ~owner;
  assign ppu_mem_ready = (state == S_RESP) &  owner;
  assign apu_mem_data  = apu_data_q;
  assign ppu_mem_data  = ppu_data_q;
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_apu_mem_arbiter.sv
module tb_apu_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [28:0] apu_mem_addr = '0;
  logic        apu_mem_read_en = 1'b0;
  logic [63:0] apu_mem_data;
  logic        apu_mem_ready;
  logic [28:0] ppu_mem_addr = '0;
  logic        ppu_mem_read_en = 1'b0;
  logic [63:0] ppu_mem_data;
  logic        ppu_mem_ready;
  logic [28:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [63:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        mem_err;
  logic        busy;

  always #5 clock = ~clock;

  apu_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset),
    .apu_mem_addr(apu_mem_addr), .apu_mem_read_en(apu_mem_read_en),
    .apu_mem_data(apu_mem_data), .apu_mem_ready(apu_mem_ready),
    .ppu_mem_addr(ppu_mem_addr), .ppu_mem_read_en(ppu_mem_read_en),
    .ppu_mem_data(ppu_mem_data), .ppu_mem_ready(ppu_mem_ready),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .mem_err(mem_err), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        ppu;
    logic        err;
    logic [63:0] data;
  } exp_t;
  exp_t expq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic p, input logic [63:0] d, input logic e);
    exp_t x;
    x.ppu = p; x.err = e; x.data = d;
    expq.push_back(x);
  endtask

  // DDR3 contents seen by the responder: fixed directed words.
  function automatic logic [63:0] mem_rd(input logic [28:0] a);
    case (a)
      29'h0000040: return 64'hDEADBEEF01234567;
      29'h0000100: return 64'h1111_0100_AAAA_0001;
      29'h0000200: return 64'h2222_0200_BBBB_0002;
      29'h1234567: return 64'h3333_4567_CCCC_0003;
      29'h0000077: return 64'h4444_0077_DDDD_0004;
      default:     return 64'hEEEE_EEEE_EEEE_EEEE;
    endcase
  endfunction

  // DDR3 responder: optional waitrequest stall, data one cycle after accept.
  int          wait_cfg = 0;
  int          wait_left = 0;
  bit          resp_en = 1'b1;
  logic        late_rdv = 1'b0;
  logic        pend = 1'b0;
  logic [63:0] pend_data = '0;
  int          read_cnt = 0;

  initial begin
    forever begin
      @(negedge clock);
      avm_readdatavalid = resp_en ? pend : late_rdv;
      avm_readdata      = resp_en ? pend_data : 64'hBAD0_BAD0_BAD0_BAD0;
      if (avm_read && wait_left > 0) begin
        avm_waitrequest = 1'b1;
        wait_left--;
      end else begin
        avm_waitrequest = 1'b0;
        if (!avm_read) wait_left = wait_cfg;
      end
      pend = avm_read && !avm_waitrequest;
      if (pend) begin
        pend_data = mem_rd(avm_address);
        read_cnt++;
      end
    end
  end

  // Scoreboard monitor: pops one expectation per ready pulse and checks that
  // both data outputs hold their last delivered value every cycle.
  logic [63:0] held_apu = '0;
  logic [63:0] held_ppu = '0;

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      held_apu <= '0;
      held_ppu <= '0;
    end else begin
      if (apu_mem_ready || ppu_mem_ready) begin
        chk("single_ready", {63'b0, apu_mem_ready & ppu_mem_ready}, 64'd0);
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready: apu=%0b ppu=%0b with no expectation at %0t",
                   apu_mem_ready, ppu_mem_ready, $time);
        end else begin
          e = expq.pop_front();
          chk("ready_port", {63'b0, ppu_mem_ready}, {63'b0, e.ppu});
          chk("ready_data", ppu_mem_ready ? ppu_mem_data : apu_mem_data, e.data);
          chk("ready_err", {63'b0, mem_err}, {63'b0, e.err});
          if (ppu_mem_ready) begin
            held_ppu = e.data;
            chk("apu_data_hold", apu_mem_data, held_apu);
          end else begin
            held_apu = e.data;
            chk("ppu_data_hold", ppu_mem_data, held_ppu);
          end
        end
      end else begin
        chk("mem_err_idle", {63'b0, mem_err}, 64'd0);
        chk("apu_data_hold", apu_mem_data, held_apu);
        chk("ppu_data_hold", ppu_mem_data, held_ppu);
      end
    end
  end

  task automatic wait_ready(input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      @(negedge clock);
      cyc++;
      if (apu_mem_ready || ppu_mem_ready) break;
    end
    checks++;
    if (!(apu_mem_ready || ppu_mem_ready)) begin
      errors++;
      $display("FAIL ready_timeout: no ready within %0d cycles", budget);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_avm_read"}, {63'b0, avm_read}, 64'd0);
    chk({tag, "_avm_address"}, {35'b0, avm_address}, 64'd0);
    chk({tag, "_apu_ready"}, {63'b0, apu_mem_ready}, 64'd0);
    chk({tag, "_ppu_ready"}, {63'b0, ppu_mem_ready}, 64'd0);
    chk({tag, "_apu_data"}, apu_mem_data, 64'd0);
    chk({tag, "_ppu_data"}, ppu_mem_data, 64'd0);
    chk({tag, "_mem_err"}, {63'b0, mem_err}, 64'd0);
    chk({tag, "_busy"}, {63'b0, busy}, 64'd0);
  endtask

  initial begin
    int cyc;
    int rc0;
    int got;
    int n;

    // Reset state, during and the cycle after.
    repeat (2) @(negedge clock);
    chk_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clock);
    chk_reset_outputs("rst_after");

    // APU-only read: avm_read at N+1 only, ready at N+3.
    rc0 = read_cnt;
    push(1'b0, 64'hDEADBEEF01234567, 1'b0);
    apu_mem_addr = 29'h0000040;
    apu_mem_read_en = 1'b1;
    @(negedge clock);
    chk("t1_avm_read", {63'b0, avm_read}, 64'd1);
    chk("t1_avm_address", {35'b0, avm_address}, 64'h40);
    chk("t1_busy", {63'b0, busy}, 64'd1);
    apu_mem_read_en = 1'b0;
    wait_ready(10, cyc);
    chk("t1_latency", 64'(cyc), 64'd2);
    @(negedge clock);
    chk("t1_idle", {63'b0, busy}, 64'd0);
    chk("t1_reads", 64'(read_cnt - rc0), 64'd1);

    // Both requesting continuously: 4 APU grants then one PPU grant.
    rc0 = read_cnt;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) push(1'b1, 64'h2222_0200_BBBB_0002, 1'b0);
      else                  push(1'b0, 64'h1111_0100_AAAA_0001, 1'b0);
    end
    apu_mem_addr = 29'h0000100;
    ppu_mem_addr = 29'h0000200;
    apu_mem_read_en = 1'b1;
    ppu_mem_read_en = 1'b1;
    got = 0;
    for (int c = 0; c < 200 && got < 10; c++) begin
      @(negedge clock);
      if (apu_mem_ready || ppu_mem_ready) got++;
    end
    apu_mem_read_en = 1'b0;
    ppu_mem_read_en = 1'b0;
    chk("t2_grants", 64'(got), 64'd10);
    repeat (2) @(negedge clock);
    chk("t2_idle", {63'b0, busy}, 64'd0);
    chk("t2_reads", 64'(read_cnt - rc0), 64'd10);

    // waitrequest high 3 cycles: read/address held for 4 cycles, one read.
    wait_cfg = 3;
    repeat (2) @(negedge clock);
    rc0 = read_cnt;
    push(1'b0, 64'h3333_4567_CCCC_0003, 1'b0);
    apu_mem_addr = 29'h1234567;
    apu_mem_read_en = 1'b1;
    @(negedge clock);
    apu_mem_read_en = 1'b0;
    n = 0;
    while (avm_read && n < 20) begin
      n++;
      chk("t3_addr_stable", {35'b0, avm_address}, 64'h1234567);
      @(negedge clock);
    end
    chk("t3_read_cycles", 64'(n), 64'd4);
    wait_ready(10, cyc);
    wait_cfg = 0;
    repeat (2) @(negedge clock);
    chk("t3_reads", 64'(read_cnt - rc0), 64'd1);

    // PPU pulses one cycle while APU owns the bus: no PPU grant.
    rc0 = read_cnt;
    push(1'b0, 64'h4444_0077_DDDD_0004, 1'b0);
    apu_mem_addr = 29'h0000077;
    apu_mem_read_en = 1'b1;
    @(negedge clock);
    apu_mem_read_en = 1'b0;
    ppu_mem_addr = 29'h0000088;
    ppu_mem_read_en = 1'b1;
    @(negedge clock);
    ppu_mem_read_en = 1'b0;
    wait_ready(10, cyc);
    repeat (4) @(negedge clock);
    chk("t4_reads", 64'(read_cnt - rc0), 64'd1);
    chk("t4_starve_cnt", {60'b0, dut.starve_cnt}, 64'd0);
    chk("t4_idle", {63'b0, busy}, 64'd0);

    // Reset in WAIT_DATA, late readdatavalid: abandoned, no ready.
    resp_en = 1'b0;
    apu_mem_addr = 29'h0000055;
    apu_mem_read_en = 1'b1;
    @(negedge clock);
    apu_mem_read_en = 1'b0;
    @(negedge clock);
    chk("t5_in_wait_busy", {63'b0, busy}, 64'd1);
    chk("t5_in_wait_read", {63'b0, avm_read}, 64'd0);
    reset = 1'b1;
    @(negedge clock);
    chk_reset_outputs("t5_rst");
    reset = 1'b0;
    late_rdv = 1'b1;
    @(negedge clock);
    chk_reset_outputs("t5_after");
    @(negedge clock);
    late_rdv = 1'b0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (apu_mem_ready || ppu_mem_ready || busy) n++;
    end
    chk("t5_quiet", 64'(n), 64'd0);
    chk("t5_apu_data", apu_mem_data, 64'd0);
    chk("t5_ppu_data", ppu_mem_data, 64'd0);

`ifdef APU_ARB_TIMEOUT_EN
    // Watchdog: 8 WAIT_DATA cycles, then ready with zero data and mem_err.
    push(1'b1, 64'h0, 1'b1);
    ppu_mem_addr = 29'h0000099;
    ppu_mem_read_en = 1'b1;
    @(negedge clock);
    ppu_mem_read_en = 1'b0;
    wait_ready(30, cyc);
    chk("t6_latency", 64'(cyc), 64'd9);
    chk("t6_mem_err", {63'b0, mem_err}, 64'd1);
    @(negedge clock);
    chk("t6_idle", {63'b0, busy}, 64'd0);
    chk("t6_err_clear", {63'b0, mem_err}, 64'd0);
`else
    // No watchdog: WAIT_DATA holds indefinitely; recover with reset.
    ppu_mem_addr = 29'h0000099;
    ppu_mem_read_en = 1'b1;
    @(negedge clock);
    ppu_mem_read_en = 1'b0;
    repeat (20) @(negedge clock);
    chk("t6_stuck_busy", {63'b0, busy}, 64'd1);
    chk("t6_no_err", {63'b0, mem_err}, 64'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("t6_recovered", {63'b0, busy}, 64'd0);
`endif
    resp_en = 1'b1;
    repeat (3) @(negedge clock);

    chk("queue_empty", 64'(expq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
